// File: rtl/linebuf_arbiter_pkg.sv
// linebuf_pkg: shared types, default sizes and row mapping
// for the line-buffer arbiter.
package linebuf_pkg;

  localparam int LB_IMG_W    = 640;
  localparam int LB_NUM_ROWS = 3;
  localparam int LB_DW       = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT
  } state_t;

  // logical row r (0 = oldest) to physical line
  function automatic int unsigned phys_row(
    input int unsigned wr_row,
    input int unsigned r,
    input int unsigned n = LB_NUM_ROWS
  );
    int unsigned s;
    s = wr_row + 1 + r;
    if (s >= n) s = s - n;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/linebuf_arbiter_if.sv
// linebuf_if: capture-write and window-read handshakes
// between the requesters (master) and the arbiter (slave).
interface linebuf_if
  import linebuf_pkg::*;
#(
  parameter int DW = LB_DW,
  parameter int CW = $clog2(LB_IMG_W),
  parameter int RW = $clog2(LB_NUM_ROWS)
) ();

  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_err;

  modport master (
    output wr_req, wr_data,
    output rd_req, rd_row, rd_col,
    input  wr_ack, rd_ack,
    input  rd_data, rd_err
  );

  modport slave (
    input  wr_req, wr_data,
    input  rd_req, rd_row, rd_col,
    output wr_ack, rd_ack,
    output rd_data, rd_err
  );

endinterface

// File: rtl/linebuf_arbiter_grant.sv
// linebuf_grant: picks write or read from the armed requests.
// LINEBUF_ARB_RR_EN: alternate on contention, else write wins.
module linebuf_grant (
  input  logic wr,
  input  logic rd,
  input  logic last_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

`ifdef LINEBUF_ARB_RR_EN
  always_comb begin
    gnt_wr = wr & (~rd | last_rd);
    gnt_rd = rd & (~wr | ~last_rd);
  end
`else
  logic unused_last;
  assign unused_last = last_rd;

  always_comb begin
    gnt_wr = wr;
    gnt_rd = rd & ~wr;
  end
`endif

endmodule

// File: rtl/linebuf_arbiter.sv
// linebuf_arbiter: owns the line-buffer RAM, rotating rows.
// Build with LINEBUF_ARB_RR_EN for round-robin arbitration.
module linebuf_arbiter
  import linebuf_pkg::*;
#(
  parameter int IMG_W    = LB_IMG_W,
  parameter int NUM_ROWS = LB_NUM_ROWS,
  parameter int DW       = LB_DW,
  parameter int CW       = $clog2(IMG_W),
  parameter int RW       = $clog2(NUM_ROWS)
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             frame_start,
  linebuf_if.slave         bus,
  output logic             mem_en,
  output logic             mem_we,
  output logic [RW+CW-1:0] mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             line_done,
  output logic             win_ready
);

  localparam int unsigned NR = NUM_ROWS;
  localparam int unsigned NW = IMG_W;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] cnt;
  logic          wr_armed;
  logic          rd_armed;
  logic          last_rd;
  logic          rd_oor;

  logic          gnt_wr;
  logic          gnt_rd;
  logic          last_col;
  logic          last_row;
  logic          rd_bad;
  logic [RW-1:0] rd_phys;

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (wr_row == RW'(NUM_ROWS - 1));
  assign win_ready = (cnt == RW'(NUM_ROWS - 1));

  assign rd_bad = (32'(bus.rd_row) >= NR)
                | (32'(bus.rd_col) >= NW);

  assign rd_phys = RW'(phys_row(32'(wr_row),
                                32'(bus.rd_row), NR));

  linebuf_grant u_grant (
    .wr      (bus.wr_req & wr_armed),
    .rd      (bus.rd_req & rd_armed),
    .last_rd (last_rd),
    .gnt_wr  (gnt_wr),
    .gnt_rd  (gnt_rd)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      line_done   <= 1'b0;
      bus.wr_ack  <= 1'b0;
      bus.rd_ack  <= 1'b0;
      bus.rd_err  <= 1'b0;
      bus.rd_data <= '0;
      col         <= '0;
      wr_row      <= '0;
      cnt         <= '0;
      wr_armed    <= 1'b1;
      rd_armed    <= 1'b1;
      last_rd     <= 1'b1;
      rd_oor      <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      line_done  <= 1'b0;
      bus.wr_ack <= 1'b0;
      bus.rd_ack <= 1'b0;
      bus.rd_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gnt_wr) begin
            state     <= WRITE;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {wr_row, col};
            mem_wdata <= bus.wr_data;
            last_rd   <= 1'b0;
          end else if (gnt_rd) begin
            // row mapping frozen here, before any later write
            state    <= READ;
            mem_en   <= ~rd_bad;
            mem_addr <= {rd_phys, bus.rd_col};
            rd_oor   <= rd_bad;
            last_rd  <= 1'b1;
          end
        end
        WRITE: begin
          state      <= IDLE;
          bus.wr_ack <= 1'b1;
          wr_armed   <= 1'b0;
          line_done  <= last_col;
          if (last_col) begin
            col    <= '0;
            wr_row <= last_row ? '0 : wr_row + 1'b1;
            if (!win_ready) cnt <= cnt + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        READ: begin
          state <= READ_WAIT;
        end
        READ_WAIT: begin
          state       <= IDLE;
          bus.rd_ack  <= 1'b1;
          bus.rd_err  <= rd_oor;
          bus.rd_data <= rd_oor ? '0 : mem_rdata;
          rd_armed    <= 1'b0;
        end
      endcase

      // a low request re-arms, even in its ack cycle
      if (!bus.wr_req) wr_armed <= 1'b1;
      if (!bus.rd_req) rd_armed <= 1'b1;

      if (frame_start) begin
        col    <= '0;
        wr_row <= '0;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: doc/linebuf_arbiter.md
Name: linebuf_arbiter

Overview:
- Owns the single-port line-buffer RAM that sits between the pixel capture front end and the convolution engine.
- Two requesters share the RAM: capture writes (Load/Load_Comp style level request with ack pulse) and convolution window reads.
- Maintains a rotating set of NUM_ROWS physical lines, the write column/row pointers and a window-ready indication.
- Translates logical row indices (0 = oldest line) into physical RAM addresses.

Parameters:
- IMG_W, 640, pixels per line.
- NUM_ROWS, 3, physical lines held in RAM (>=2).
- DW, 16, pixel width in bits.
- CW, $clog2(IMG_W), column address width.
- RW, $clog2(NUM_ROWS), row address width.

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse; restarts line bookkeeping.
- wr_req  in  1  capture write request, level (connects to Load).
- wr_data  in  DW  pixel to write.
- wr_ack  out  1  one-cycle write-done pulse (connects to Load_Comp).
- rd_req  in  1  convolution read request, level.
- rd_row  in  RW  logical row, 0 = oldest stored line.
- rd_col  in  CW  column to read.
- rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle.
- rd_data  out  DW  read pixel.
- rd_err  out  1  pulses with rd_ack when rd_row/rd_col is out of range.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  RW+CW  RAM address, {phys_row, col}.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, registered, 1-cycle latency.
- line_done  out  1  one-cycle pulse when the last column of a line is written.
- win_ready  out  1  level; high once >= NUM_ROWS-1 complete lines exist since frame_start.

Behaviour:
- Reset values: all outputs 0; state IDLE; col = 0, wr_row = 0, line count = 0; both armed flags = 1.
- FSM states: IDLE, WRITE, READ, READ_WAIT.
- IDLE:
  - Picks a grant from the armed requests.
  - Write grant: go to WRITE.
  - Read grant: go to READ.
  - No armed request: stay in IDLE.
- WRITE (1 cycle):
  - mem_en = mem_we = 1, mem_addr = {wr_row, col}, mem_wdata = wr_data.
  - wr_ack = 1; clear wr_armed; return to IDLE.
- READ (1 cycle): mem_en = 1, mem_we = 0, mem_addr = {phys(rd_row), rd_col}; go to READ_WAIT.
- READ_WAIT (1 cycle): rd_data <= mem_rdata, rd_ack = 1; clear rd_armed; return to IDLE.
- Latencies:
  - Write: wr_ack 2 cycles after wr_req is first sampled in IDLE.
  - Read: rd_ack 3 cycles after rd_req is first sampled in IDLE.
  - rd_data holds its value until the next rd_ack.
- Re-arm rule: a request is eligible only while its armed flag is 1. The flag is set in any cycle where the request is low. Because of this, a request held high for one cycle past its ack is never serviced twice.
- Arbitration (default): strict write priority when both requests are armed in IDLE.
- Physical row mapping: phys(r) = (wr_row + 1 + r) mod NUM_ROWS, so row NUM_ROWS-1 is the line currently being filled. This mapping is evaluated from the wr_row value at grant time.
- Out of range (rd_row >= NUM_ROWS or rd_col >= IMG_W):
  - mem_en stays 0 in READ.
  - At rd_ack: rd_data = 0 and rd_err = 1.
- Column wrap: on a WRITE with col == IMG_W-1:
  - col -> 0, and wr_row -> (wr_row+1) mod NUM_ROWS.
  - line_done pulses in the same cycle as wr_ack.
  - Line count increments, saturating at NUM_ROWS-1.
  - Otherwise col increments.
- win_ready = (line count == NUM_ROWS-1).
- frame_start:
  - Clears col, wr_row, line count and win_ready in the next cycle.
  - If it coincides with WRITE, the write completes to the old address, then the counters are cleared. frame_start takes precedence over the increment.
  - An in-flight read completes normally.
- rst mid-operation: any state goes to IDLE immediately; a pending ack is dropped.

Optional Feature:
- Macro: LINEBUF_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are armed, the grant goes to the requester not served last. The last-grant bit resets to "read", so the first contention goes to write.
- Undefined: strict write priority as described under Behaviour.

Decomposition:
- Package linebuf_pkg contains:
  - state enum (IDLE, WRITE, READ, READ_WAIT);
  - default IMG_W, NUM_ROWS and DW constants;
  - a function phys_row(wr_row, r) returning the modulo mapping.
- One sub-module, linebuf_grant: combinational/registered arbiter. It takes the armed requests and the last-grant bit, and outputs the grant. The RR option lives only here.

Test Plan:
- Reset, then wr_req held high for 3 cycles with wr_data = 16'hA5A5 -> exactly one wr_ack; mem_addr = 0 and mem_we = 1 in the WRITE cycle.
- Write IMG_W = 640 pixels -> line_done on the 640th wr_ack, wr_row = 1, win_ready = 0. Write 640 more -> win_ready = 1.
- After 2 full lines plus 5 pixels, read rd_row = 0, rd_col = 7 -> mem_addr = {2'd0, 10'd7}, rd_ack 3 cycles after the request, rd_data equals the written pixel.
- wr_req and rd_req armed together in IDLE:
  - default build: write first;
  - LINEBUF_ARB_RR_EN build: write first, then read on the next contention.
- rd_col = 700 -> rd_err = 1, rd_data = 0, mem_en stays 0.
- frame_start during a WRITE at col = 639 -> wr_ack is issued, then col = 0, wr_row = 0 and win_ready = 0. rst asserted in READ -> IDLE with no rd_ack.
